// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-controller bus: PC and instruction-memory side on master,
// fetch controller on slave.
interface instr_fetch_ctrl_if #(
  parameter int IMEM_WORDS = 256
);
  localparam int AW = $clog2(IMEM_WORDS);

  logic [31:0]   pc_reg;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          finish_flag;
  logic          fault;
  logic [1:0]    fault_cause;
  logic [31:0]   instr_count;

  modport master (
    output pc_reg, imem_rdata,
    input  imem_addr, instr, instr_valid, finish_flag, fault, fault_cause, instr_count
  );

  modport slave (
    input  pc_reg, imem_rdata,
    output imem_addr, instr, instr_valid, finish_flag, fault, fault_cause, instr_count
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: qualifies each fetched word, detects program
// end (halt word or PC self-loop) and PC faults, and counts retired instructions.
module instr_fetch_ctrl #(
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073,
  parameter int          LOOP_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  instr_fetch_ctrl_if.slave bus
);
  localparam int          AW        = $clog2(IMEM_WORDS);
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] PC_LIMIT  = 32'(4 * IMEM_WORDS);
  localparam logic [7:0]  SAME_HALT = 8'(LOOP_LIMIT - 2);

  typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_e;

  state_e      state_q;
  logic        finish_q;
  logic        fault_q;
  logic [1:0]  cause_q;
  logic [31:0] count_q;
  logic [31:0] prev_pc_q;
  logic        prev_vld_q;
  logic [7:0]  same_cnt_q;

  logic misaligned;
  logic out_of_range;
  logic halt_hit;
  logic same_pc;
  logic loop_hit;
  logic fetch_ok;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    misaligned   = (bus.pc_reg[1:0] != 2'b00);
    out_of_range = (bus.pc_reg >= PC_LIMIT);
    halt_hit     = (bus.imem_rdata == HALT_INSTR);
    // No valid previous PC exists in the first RUN cycle after IDLE.
    same_pc      = prev_vld_q && (bus.pc_reg == prev_pc_q);
    loop_hit     = same_pc && (same_cnt_q == SAME_HALT);
    fetch_ok     = (state_q == RUN) && !misaligned && !out_of_range && !halt_hit;

    bus.imem_addr   = bus.pc_reg[AW+1:2];
    bus.instr_valid = fetch_ok;
    bus.instr       = fetch_ok ? bus.imem_rdata : NOP;
  end

  assign bus.finish_flag = finish_q;
  assign bus.fault       = fault_q;
  assign bus.fault_cause = cause_q;
  assign bus.instr_count = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      finish_q   <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= 2'b00;
      count_q    <= 32'd0;
      prev_pc_q  <= 32'd0;
      prev_vld_q <= 1'b0;
      same_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= RUN;
          prev_vld_q <= 1'b0;
        end
        RUN: begin
          prev_pc_q  <= bus.pc_reg;
          prev_vld_q <= 1'b1;
          same_cnt_q <= same_pc ? same_cnt_q + 8'd1 : 8'd0;
          if (misaligned) begin
            state_q  <= FAULT;
            finish_q <= 1'b1;
            fault_q  <= 1'b1;
            cause_q  <= 2'b01;
          end else if (out_of_range) begin
            state_q  <= FAULT;
            finish_q <= 1'b1;
            fault_q  <= 1'b1;
            cause_q  <= 2'b10;
          end else if (halt_hit) begin
            state_q  <= HALTED;
            finish_q <= 1'b1;
          end else begin
            // The loop instruction itself still retires before halting.
            count_q <= sat_inc(count_q);
            if (loop_hit) begin
              state_q  <= HALTED;
              finish_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: normal program, faults, self-loop halt,
// asynchronous reset and counter saturation.
module tb_instr_fetch_ctrl;
  localparam logic [31:0] HALT = 32'h0000_0073;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk;
  logic reset;
  logic [31:0] mem [0:255];
  int checks;
  int errors;

  instr_fetch_ctrl_if #(.IMEM_WORDS(256)) ifc ();

  instr_fetch_ctrl #(
    .IMEM_WORDS(256),
    .HALT_INSTR(HALT),
    .LOOP_LIMIT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  assign ifc.imem_rdata = mem[ifc.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    ifc.pc_reg = pc;
    #2;
  endtask

  // Reset, then sit through the IDLE cycle so the DUT is in its first RUN cycle.
  task automatic start();
    reset = 1'b1;
    ifc.pc_reg = 32'd0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.pc_reg = 32'd0;
    tick();
    checks++; if (ifc.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", ifc.instr_valid); end
    checks++; if (ifc.instr !== NOP) begin errors++; $display("FAIL rst_instr got %h exp %h", ifc.instr, NOP); end
    checks++; if (ifc.finish_flag !== 1'b0) begin errors++; $display("FAIL rst_finish got %0b exp 0", ifc.finish_flag); end
    checks++; if (ifc.fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %0b exp 0", ifc.fault); end
    checks++; if (ifc.fault_cause !== 2'b00) begin errors++; $display("FAIL rst_cause got %b exp 00", ifc.fault_cause); end
    checks++; if (ifc.instr_count !== 32'd0) begin errors++; $display("FAIL rst_count got %h exp 0", ifc.instr_count); end
    reset = 1'b0;
    set_pc(32'd0);
    checks++; if (ifc.instr_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %0b exp 0", ifc.instr_valid); end
    checks++; if (ifc.imem_addr !== 8'd0) begin errors++; $display("FAIL idle_addr got %h exp 0", ifc.imem_addr); end
  endtask

  task automatic test_program();
    start();
    for (int i = 0; i < 8; i++) begin
      set_pc(32'(4 * i));
      checks++; if (ifc.imem_addr !== 8'(i)) begin errors++; $display("FAIL prog_addr%0d got %h exp %h", i, ifc.imem_addr, 8'(i)); end
      checks++; if (ifc.instr_valid !== 1'b1) begin errors++; $display("FAIL prog_valid%0d got %0b exp 1", i, ifc.instr_valid); end
      checks++; if (ifc.instr !== (32'h1000_0000 | 32'(i))) begin errors++; $display("FAIL prog_instr%0d got %h exp %h", i, ifc.instr, 32'h1000_0000 | 32'(i)); end
      tick();
    end
    set_pc(32'h20);
    checks++; if (ifc.instr_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %0b exp 0", ifc.instr_valid); end
    checks++; if (ifc.finish_flag !== 1'b0) begin errors++; $display("FAIL halt_early_finish got %0b exp 0", ifc.finish_flag); end
    tick();
    checks++; if (ifc.finish_flag !== 1'b1) begin errors++; $display("FAIL halt_finish got %0b exp 1", ifc.finish_flag); end
    checks++; if (ifc.instr_count !== 32'd8) begin errors++; $display("FAIL halt_count got %0d exp 8", ifc.instr_count); end
    checks++; if (ifc.fault !== 1'b0) begin errors++; $display("FAIL halt_fault got %0b exp 0", ifc.fault); end
    set_pc(32'h06);
    tick();
    checks++; if (ifc.instr_valid !== 1'b0 || ifc.fault !== 1'b0 || ifc.instr_count !== 32'd8) begin
      errors++; $display("FAIL halted_inert valid %0b fault %0b count %0d exp 0 0 8", ifc.instr_valid, ifc.fault, ifc.instr_count);
    end
    set_pc(32'h20);
  endtask

  task automatic test_reset_pulse();
    #2;
    reset = 1'b1;
    #3;
    checks++; if (ifc.finish_flag !== 1'b0 || ifc.fault !== 1'b0 || ifc.fault_cause !== 2'b00) begin
      errors++; $display("FAIL pulse_flags finish %0b fault %0b cause %b exp 0 0 00", ifc.finish_flag, ifc.fault, ifc.fault_cause);
    end
    checks++; if (ifc.instr_count !== 32'd0) begin errors++; $display("FAIL pulse_count got %0d exp 0", ifc.instr_count); end
    checks++; if (ifc.instr_valid !== 1'b0 || ifc.instr !== NOP) begin
      errors++; $display("FAIL pulse_instr valid %0b instr %h exp 0 %h", ifc.instr_valid, ifc.instr, NOP);
    end
    reset = 1'b0;
    ifc.pc_reg = 32'd0;
    #1;
    checks++; if (ifc.instr_valid !== 1'b0) begin errors++; $display("FAIL pulse_idle_valid got %0b exp 0", ifc.instr_valid); end
    tick();
    checks++; if (ifc.instr_valid !== 1'b1 || ifc.instr !== 32'h1000_0000) begin
      errors++; $display("FAIL pulse_first valid %0b instr %h exp 1 10000000", ifc.instr_valid, ifc.instr);
    end
    tick();
    checks++; if (ifc.instr_count !== 32'd1) begin errors++; $display("FAIL pulse_count1 got %0d exp 1", ifc.instr_count); end
  endtask

  task automatic test_misaligned();
    start();
    set_pc(32'h0);
    tick();
    set_pc(32'h6);
    checks++; if (ifc.instr_valid !== 1'b0 || ifc.instr !== NOP) begin
      errors++; $display("FAIL mis_valid valid %0b instr %h exp 0 %h", ifc.instr_valid, ifc.instr, NOP);
    end
    tick();
    checks++; if (ifc.fault !== 1'b1) begin errors++; $display("FAIL mis_fault got %0b exp 1", ifc.fault); end
    checks++; if (ifc.fault_cause !== 2'b01) begin errors++; $display("FAIL mis_cause got %b exp 01", ifc.fault_cause); end
    checks++; if (ifc.finish_flag !== 1'b1) begin errors++; $display("FAIL mis_finish got %0b exp 1", ifc.finish_flag); end
    checks++; if (ifc.instr_count !== 32'd1) begin errors++; $display("FAIL mis_count got %0d exp 1", ifc.instr_count); end
    set_pc(32'h400);
    tick();
    checks++; if (ifc.fault_cause !== 2'b01) begin errors++; $display("FAIL mis_cause_hold got %b exp 01", ifc.fault_cause); end
  endtask

  task automatic test_range();
    start();
    set_pc(32'h3FC);
    checks++; if (ifc.instr_valid !== 1'b1 || ifc.instr !== 32'h1000_00FF) begin
      errors++; $display("FAIL rng_last valid %0b instr %h exp 1 100000ff", ifc.instr_valid, ifc.instr);
    end
    tick();
    checks++; if (ifc.fault !== 1'b0 || ifc.finish_flag !== 1'b0) begin
      errors++; $display("FAIL rng_last_nofault fault %0b finish %0b exp 0 0", ifc.fault, ifc.finish_flag);
    end
    set_pc(32'h400);
    checks++; if (ifc.instr_valid !== 1'b0) begin errors++; $display("FAIL rng_valid got %0b exp 0", ifc.instr_valid); end
    tick();
    checks++; if (ifc.fault !== 1'b1 || ifc.fault_cause !== 2'b10) begin
      errors++; $display("FAIL rng_fault fault %0b cause %b exp 1 10", ifc.fault, ifc.fault_cause);
    end
    checks++; if (ifc.instr_count !== 32'd1) begin errors++; $display("FAIL rng_count got %0d exp 1", ifc.instr_count); end
  endtask

  task automatic test_self_loop();
    start();
    set_pc(32'h0);
    tick();
    set_pc(32'h10);
    tick();
    checks++; if (ifc.instr_count !== 32'd2) begin errors++; $display("FAIL loop_base got %0d exp 2", ifc.instr_count); end
    for (int i = 0; i < 2; i++) begin
      set_pc(32'h10);
      tick();
      checks++; if (ifc.finish_flag !== 1'b0) begin errors++; $display("FAIL loop_early%0d got %0b exp 0", i, ifc.finish_flag); end
    end
    set_pc(32'h10);
    checks++; if (ifc.instr_valid !== 1'b1) begin errors++; $display("FAIL loop_last_valid got %0b exp 1", ifc.instr_valid); end
    tick();
    checks++; if (ifc.finish_flag !== 1'b1) begin errors++; $display("FAIL loop_finish got %0b exp 1", ifc.finish_flag); end
    checks++; if (ifc.instr_count !== 32'd5) begin errors++; $display("FAIL loop_count got %0d exp 5", ifc.instr_count); end
    checks++; if (ifc.fault !== 1'b0 || ifc.instr_valid !== 1'b0) begin
      errors++; $display("FAIL loop_after fault %0b valid %0b exp 0 0", ifc.fault, ifc.instr_valid);
    end
  endtask

  task automatic test_saturation();
    start();
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    for (int i = 0; i < 3; i++) begin
      set_pc(32'(4 * i));
      tick();
      checks++; if (ifc.instr_count !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL sat_count%0d got %h exp ffffffff", i, ifc.instr_count);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    ifc.pc_reg = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[8] = HALT;
    test_reset();
    test_program();
    test_reset_pulse();
    test_misaligned();
    test_range();
    test_self_loop();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
